alarm_timekeeper: RTL and testbench

Parametrised timekeeping and alarm core for the alarm-clock jukebox FPGA design. It keeps HH:MM:SS time from the system clock and holds a settable alarm time. It drives six seven-segment digit outputs, supports 12 h and 24 h display, and runs an alarm state machine with snooze, stop and timeout that outputs a square-wave speaker tone. It sits beside the soft-processor system and takes pre-debounced single-cycle button pulses.

---
 rtl/alarm_pkg.sv | 22 ++
 rtl/alarm_timekeeper_seg7_encoder.sv | 23 ++
 rtl/alarm_timekeeper.sv | 255 +++++++++++++++++++++++++
 tb/tb_alarm_timekeeper.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm timekeeper: FSM states, set_sel codes
// and the seven-segment lookup table.
package alarm_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StRinging,
      StSnoozed
   } alarm_state_e;

   localparam logic [1:0] SEL_RUN   = 2'b00;
   localparam logic [1:0] SEL_TIME  = 2'b01;
   localparam logic [1:0] SEL_ALARM = 2'b10;

   // Segment patterns in gfedcba order, lit = 1; index is the decimal digit.
   localparam logic [9:0][6:0] SEG_TABLE = {
      7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
      7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };
   localparam logic [6:0] SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/alarm_timekeeper_seg7_encoder.sv
// Decimal digit to seven-segment pattern, with blanking and optional
// active-low output polarity.
module seg7_encoder
   import alarm_pkg::*;
#(
   parameter int unsigned SEG_ACTIVE_LOW = 1
) (
   input  logic [3:0] digit_i,
   input  logic       blank_i,
   output logic [6:0] seg_o
);

   logic [6:0] pattern;

   always_comb begin
      pattern = SEG_BLANK;
      if (!blank_i && (digit_i <= 4'd9)) begin
         pattern = SEG_TABLE[digit_i];
      end
      seg_o = (SEG_ACTIVE_LOW != 0) ? ~pattern : pattern;
   end

endmodule

// File: rtl/alarm_timekeeper.sv
// HH:MM:SS timekeeper with settable alarm, 12/24 h seven-segment display and an
// alarm FSM (ring, snooze, stop, timeout) driving a square-wave speaker.
module alarm_timekeeper
   import alarm_pkg::*;
#(
   parameter int unsigned CLK_HZ         = 50000000,
   parameter int unsigned TONE_HZ        = 440,
   parameter int unsigned SNOOZE_S       = 300,
   parameter int unsigned RING_TIMEOUT_S = 60,
   parameter int unsigned SEG_ACTIVE_LOW = 1
) (
   input  logic       clk_clk,
   input  logic       reset_reset_n,
   input  logic [1:0] set_sel,
   input  logic       inc_hour,
   input  logic       inc_min,
   input  logic       mode_12h,
   input  logic       alarm_en,
   input  logic       snooze,
   input  logic       stop,
   output logic [6:0] hour1,
   output logic [6:0] hour0,
   output logic [6:0] min1,
   output logic [6:0] min0,
   output logic [6:0] sec1,
   output logic [6:0] sec0,
   output logic       speaker,
   output logic       alarm_active,
   output logic       pm,
   output logic       tick_1hz
);

   localparam int unsigned HalfPeriod = (CLK_HZ / (2 * TONE_HZ) > 0) ? CLK_HZ / (2 * TONE_HZ) : 1;
   localparam int unsigned PreW  = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam int unsigned ToneW = (HalfPeriod > 1) ? $clog2(HalfPeriod) : 1;
   localparam int unsigned SnzW  = (SNOOZE_S > 0) ? $clog2(SNOOZE_S + 1) : 1;
   localparam int unsigned RingW = (RING_TIMEOUT_S > 0) ? $clog2(RING_TIMEOUT_S + 1) : 1;

   localparam logic [PreW-1:0]  PreMax   = PreW'(CLK_HZ - 1);
   localparam logic [ToneW-1:0] ToneMax  = ToneW'(HalfPeriod - 1);
   localparam logic [SnzW-1:0]  SnzLoad  = SnzW'(SNOOZE_S);
   localparam logic [RingW-1:0] RingLast = RingW'((RING_TIMEOUT_S > 0) ? RING_TIMEOUT_S - 1 : 0);

   logic time_mode, alarm_mode, run_mode, tick, alarm_hit;

   logic [PreW-1:0] presc_q, presc_d;
   logic [4:0] hour_q, hour_d, al_hour_q, al_hour_d, hour_inc, al_hour_inc;
   logic [5:0] min_q, min_d, al_min_q, al_min_d, min_inc, al_min_inc;
   logic [5:0] sec_q, sec_d, sec_inc;

   alarm_state_e     state_q;
   logic [ToneW-1:0] tone_q;
   logic [RingW-1:0] ring_q;
   logic [SnzW-1:0]  snz_q;
   logic             speaker_q, active_q;

   logic [4:0] src_hour, shown_hour;
   logic [5:0] src_min;
   logic [3:0] hour_t_q, hour_u_q, min_t_q, min_u_q, sec_t_q, sec_u_q;
   logic [3:0] hour_t_d, hour_u_d, min_t_d, min_u_d, sec_t_d, sec_u_d;
   logic       hour_t_blank_q, hour_t_blank_d, sec_blank_q, sec_blank_d, pm_q, pm_d;

   assign time_mode  = (set_sel == SEL_TIME);
   assign alarm_mode = (set_sel == SEL_ALARM);
   assign run_mode   = !(time_mode || alarm_mode);
   assign tick       = !time_mode && (presc_q == PreMax);

   always_comb begin
      sec_inc     = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
      min_inc     = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
      hour_inc    = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
      al_min_inc  = (al_min_q == 6'd59) ? 6'd0 : al_min_q + 6'd1;
      al_hour_inc = (al_hour_q == 5'd23) ? 5'd0 : al_hour_q + 5'd1;

      presc_d   = presc_q;
      sec_d     = sec_q;
      min_d     = min_q;
      hour_d    = hour_q;
      al_min_d  = al_min_q;
      al_hour_d = al_hour_q;

      if (time_mode) begin
         presc_d = '0;
         sec_d   = '0;
         if (inc_hour) hour_d = hour_inc;
         if (inc_min)  min_d  = min_inc;
      end else begin
         presc_d = tick ? '0 : presc_q + PreW'(1);
         if (tick) begin
            sec_d = sec_inc;
            if (sec_q == 6'd59) begin
               min_d = min_inc;
               if (min_q == 6'd59) hour_d = hour_inc;
            end
         end
         if (alarm_mode) begin
            if (inc_hour) al_hour_d = al_hour_inc;
            if (inc_min)  al_min_d  = al_min_inc;
         end
      end
   end

   // Compare against the time as it will be after this tick lands.
   assign alarm_hit = tick && run_mode && alarm_en && (sec_d == 6'd0) &&
                      (min_d == al_min_q) && (hour_d == al_hour_q);

   always_comb begin
      src_hour   = alarm_mode ? al_hour_q : hour_q;
      src_min    = alarm_mode ? al_min_q : min_q;
      shown_hour = src_hour;
      if (mode_12h) begin
         if (src_hour == 5'd0) shown_hour = 5'd12;
         else if (src_hour > 5'd12) shown_hour = src_hour - 5'd12;
      end
      hour_t_d       = 4'(shown_hour / 5'd10);
      hour_u_d       = 4'(shown_hour % 5'd10);
      min_t_d        = 4'(src_min / 6'd10);
      min_u_d        = 4'(src_min % 6'd10);
      sec_t_d        = 4'(sec_q / 6'd10);
      sec_u_d        = 4'(sec_q % 6'd10);
      hour_t_blank_d = mode_12h && (shown_hour < 5'd10);
      sec_blank_d    = alarm_mode;
      pm_d           = mode_12h && (src_hour >= 5'd12);
   end

   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         presc_q        <= '0;
         sec_q          <= '0;
         min_q          <= '0;
         hour_q         <= '0;
         al_min_q       <= '0;
         al_hour_q      <= '0;
         hour_t_q       <= '0;
         hour_u_q       <= '0;
         min_t_q        <= '0;
         min_u_q        <= '0;
         sec_t_q        <= '0;
         sec_u_q        <= '0;
         hour_t_blank_q <= 1'b0;
         sec_blank_q    <= 1'b0;
         pm_q           <= 1'b0;
      end else begin
         presc_q        <= presc_d;
         sec_q          <= sec_d;
         min_q          <= min_d;
         hour_q         <= hour_d;
         al_min_q       <= al_min_d;
         al_hour_q      <= al_hour_d;
         hour_t_q       <= hour_t_d;
         hour_u_q       <= hour_u_d;
         min_t_q        <= min_t_d;
         min_u_q        <= min_u_d;
         sec_t_q        <= sec_t_d;
         sec_u_q        <= sec_u_d;
         hour_t_blank_q <= hour_t_blank_d;
         sec_blank_q    <= sec_blank_d;
         pm_q           <= pm_d;
      end
   end

   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         state_q   <= StIdle;
         tone_q    <= '0;
         ring_q    <= '0;
         snz_q     <= '0;
         speaker_q <= 1'b0;
         active_q  <= 1'b0;
      end else if (!run_mode) begin
         state_q   <= StIdle;
         tone_q    <= '0;
         speaker_q <= 1'b0;
         active_q  <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               tone_q    <= '0;
               speaker_q <= 1'b0;
               if (alarm_hit) begin
                  state_q  <= StRinging;
                  ring_q   <= '0;
                  active_q <= 1'b1;
               end
            end
            StRinging: begin
               if (stop || !alarm_en || (tick && !snooze && (ring_q >= RingLast))) begin
                  state_q   <= StIdle;
                  tone_q    <= '0;
                  speaker_q <= 1'b0;
                  active_q  <= 1'b0;
               end else if (snooze) begin
                  state_q   <= StSnoozed;
                  snz_q     <= SnzLoad;
                  tone_q    <= '0;
                  speaker_q <= 1'b0;
               end else begin
                  if (tone_q == ToneMax) begin
                     tone_q    <= '0;
                     speaker_q <= ~speaker_q;
                  end else begin
                     tone_q <= tone_q + ToneW'(1);
                  end
                  if (tick) ring_q <= ring_q + RingW'(1);
               end
            end
            StSnoozed: begin
               tone_q    <= '0;
               speaker_q <= 1'b0;
               if (stop || !alarm_en) begin
                  state_q  <= StIdle;
                  active_q <= 1'b0;
               end else if (tick) begin
                  if (snz_q <= SnzW'(1)) begin
                     state_q <= StRinging;
                     ring_q  <= '0;
                     snz_q   <= '0;
                  end else begin
                     snz_q <= snz_q - SnzW'(1);
                  end
               end
            end
            default: begin
               state_q  <= StIdle;
               active_q <= 1'b0;
            end
         endcase
      end
   end

   assign speaker      = speaker_q;
   assign alarm_active = active_q;
   assign pm           = pm_q;
   assign tick_1hz     = tick;

   seg7_encoder #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_hour1 (
      .digit_i(hour_t_q), .blank_i(hour_t_blank_q), .seg_o(hour1)
   );
   seg7_encoder #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_hour0 (
      .digit_i(hour_u_q), .blank_i(1'b0), .seg_o(hour0)
   );
   seg7_encoder #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_min1 (
      .digit_i(min_t_q), .blank_i(1'b0), .seg_o(min1)
   );
   seg7_encoder #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_min0 (
      .digit_i(min_u_q), .blank_i(1'b0), .seg_o(min0)
   );
   seg7_encoder #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_sec1 (
      .digit_i(sec_t_q), .blank_i(sec_blank_q), .seg_o(sec1)
   );
   seg7_encoder #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_sec0 (
      .digit_i(sec_u_q), .blank_i(sec_blank_q), .seg_o(sec0)
   );

endmodule

// File: tb/tb_alarm_timekeeper.sv
// Directed bench for alarm_timekeeper with a 10-cycle second, 5-cycle tone
// half-period, 3 s snooze and 4 s ring timeout.
module tb_alarm_timekeeper;

   localparam int BLANK = 10;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] set_sel = 2'b00;
   logic       inc_hour = 1'b0, inc_min = 1'b0, mode_12h = 1'b0;
   logic       alarm_en = 1'b0, snooze = 1'b0, stop = 1'b0;
   logic [6:0] hour1, hour0, min1, min0, sec1, sec0;
   logic       speaker, alarm_active, pm, tick_1hz;

   int tests_run = 0;
   int fails = 0;

   always #5 clk = ~clk;

   alarm_timekeeper #(
      .CLK_HZ(10), .TONE_HZ(1), .SNOOZE_S(3), .RING_TIMEOUT_S(4), .SEG_ACTIVE_LOW(1)
   ) dut (
      .clk_clk(clk), .reset_reset_n(rst_n), .set_sel(set_sel),
      .inc_hour(inc_hour), .inc_min(inc_min), .mode_12h(mode_12h),
      .alarm_en(alarm_en), .snooze(snooze), .stop(stop),
      .hour1(hour1), .hour0(hour0), .min1(min1), .min0(min0), .sec1(sec1), .sec0(sec0),
      .speaker(speaker), .alarm_active(alarm_active), .pm(pm), .tick_1hz(tick_1hz)
   );

   // Active-low segment pattern expected for a digit (BLANK = all segments off).
   function automatic logic [6:0] seg(input int d);
      logic [6:0] p;
      case (d)
         0: p = 7'b0111111;
         1: p = 7'b0000110;
         2: p = 7'b1011011;
         3: p = 7'b1001111;
         4: p = 7'b1100110;
         5: p = 7'b1101101;
         6: p = 7'b1111101;
         7: p = 7'b0000111;
         8: p = 7'b1111111;
         9: p = 7'b1101111;
         default: p = 7'b0000000;
      endcase
      return ~p;
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_disp(input string tag, input int h1, input int h0, input int m1,
                             input int m0, input int s1, input int s0);
      check({tag, ".hour1"}, 32'(hour1), 32'(seg(h1)));
      check({tag, ".hour0"}, 32'(hour0), 32'(seg(h0)));
      check({tag, ".min1"}, 32'(min1), 32'(seg(m1)));
      check({tag, ".min0"}, 32'(min0), 32'(seg(m0)));
      check({tag, ".sec1"}, 32'(sec1), 32'(seg(s1)));
      check({tag, ".sec0"}, 32'(sec0), 32'(seg(s0)));
   endtask

   task automatic pulse(input logic h, input logic m, input int n);
      for (int i = 0; i < n; i++) begin
         inc_hour = h;
         inc_min  = m;
         step(1);
         inc_hour = 1'b0;
         inc_min  = 1'b0;
      end
   endtask

   initial begin
      // Reset state
      step(2);
      check_disp("reset", 0, 0, 0, 0, 0, 0);
      check("reset.speaker", 32'(speaker), 0);
      check("reset.active", 32'(alarm_active), 0);
      check("reset.pm", 32'(pm), 0);
      check("reset.tick", 32'(tick_1hz), 0);
      rst_n = 1'b1;

      // First second: tick on the 10th cycle, sec0 shows 1 a cycle later
      step(8);
      check("pre_tick", 32'(tick_1hz), 0);
      step(1);
      check("tick", 32'(tick_1hz), 1);
      step(1);
      check("tick_one_cycle", 32'(tick_1hz), 0);
      step(1);
      check_disp("one_sec", 0, 0, 0, 0, 0, 1);

      // Set time: simultaneous pulses, then 23:59, minute wrap, hour wrap
      set_sel = 2'b01;
      pulse(1'b1, 1'b1, 1);
      step(1);
      check_disp("set_both", 0, 1, 0, 1, 0, 0);
      pulse(1'b1, 1'b0, 22);
      pulse(1'b0, 1'b1, 58);
      step(1);
      check_disp("set_2359", 2, 3, 5, 9, 0, 0);
      mode_12h = 1'b1;
      step(1);
      check_disp("12h_23", 1, 1, 5, 9, 0, 0);
      check("12h_23.pm", 32'(pm), 1);
      mode_12h = 1'b0;
      pulse(1'b0, 1'b1, 1);
      step(1);
      check_disp("min_wrap", 2, 3, 0, 0, 0, 0);
      pulse(1'b0, 1'b1, 59);
      pulse(1'b1, 1'b0, 1);
      step(1);
      check_disp("hour_wrap", 0, 0, 5, 9, 0, 0);
      pulse(1'b1, 1'b0, 23);

      // Run from 23:59:00 to 23:59:58 and across midnight
      set_sel = 2'b00;
      step(581);
      check_disp("t_235958", 2, 3, 5, 9, 5, 8);
      step(20);
      check_disp("midnight", 0, 0, 0, 0, 0, 0);
      mode_12h = 1'b1;
      step(1);
      check_disp("midnight_12h", 1, 2, 0, 0, 0, 0);
      check("midnight_12h.pm", 32'(pm), 0);

      // Set alarm 06:30: alarm shown with seconds blanked, hour1 blanked in 12 h
      set_sel = 2'b10;
      pulse(1'b1, 1'b0, 6);
      pulse(1'b0, 1'b1, 30);
      step(1);
      check_disp("alarm_12h", BLANK, 6, 3, 0, BLANK, BLANK);
      mode_12h = 1'b0;
      step(1);
      check_disp("alarm_24h", 0, 6, 3, 0, BLANK, BLANK);

      // Time 06:29:00, run to 06:29:59, next tick rings
      set_sel = 2'b01;
      pulse(1'b1, 1'b0, 6);
      pulse(1'b0, 1'b1, 29);
      alarm_en = 1'b1;
      set_sel  = 2'b00;
      step(599);
      check_disp("t_062959", 0, 6, 2, 9, 5, 9);
      check("pre_ring.active", 32'(alarm_active), 0);
      step(1);
      check("ring.active", 32'(alarm_active), 1);
      check("ring.spk0", 32'(speaker), 0);
      step(4);
      check("ring.spk_c4", 32'(speaker), 0);
      step(1);
      check("ring.spk_c5", 32'(speaker), 1);
      step(5);
      check("ring.spk_c10", 32'(speaker), 0);

      // Stop and snooze together: stop wins
      snooze = 1'b1;
      stop   = 1'b1;
      step(1);
      snooze = 1'b0;
      stop   = 1'b0;
      check("stop.active", 32'(alarm_active), 0);
      check("stop.spk", 32'(speaker), 0);

      // Re-arm: snooze for 3 s, ring again, then time out after 4 s
      set_sel = 2'b01;
      pulse(1'b0, 1'b1, 59);
      set_sel = 2'b00;
      step(600);
      check("ring2.active", 32'(alarm_active), 1);
      snooze = 1'b1;
      step(1);
      snooze = 1'b0;
      check("snz.active", 32'(alarm_active), 1);
      check("snz.spk", 32'(speaker), 0);
      step(28);
      check("snz_end.spk", 32'(speaker), 0);
      check("snz_end.active", 32'(alarm_active), 1);
      step(6);
      check("reringing.spk", 32'(speaker), 1);
      step(34);
      check("pre_timeout.active", 32'(alarm_active), 1);
      step(1);
      check("timeout.active", 32'(alarm_active), 0);
      check("timeout.spk", 32'(speaker), 0);

      // Reset while ringing
      set_sel = 2'b01;
      pulse(1'b0, 1'b1, 59);
      set_sel = 2'b00;
      step(605);
      check("ring3.active", 32'(alarm_active), 1);
      check("ring3.spk", 32'(speaker), 1);
      rst_n = 1'b0;
      step(1);
      check("rst_ring.active", 32'(alarm_active), 0);
      check("rst_ring.spk", 32'(speaker), 0);
      check_disp("rst_ring", 0, 0, 0, 0, 0, 0);
      rst_n = 1'b1;
      step(2);

      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
